axis_dest_demux: RTL

AXI4-Stream 1-to-M_COUNT demultiplexer that routes whole packets by tdest. It is the fan-out counterpart of the arbitrated mux: it sits downstream of a shared stream and splits it back into per-destination streams. The output is pipelined with a registered skid buffer, so the ready path is fully registered. The route is latched on the first beat of each packet and held until tlast.

---
 rtl/axis_dest_demux.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_dest_demux.sv
// ---------------------------------------------------------------------------
// axis_dest_demux
//
// AXI4-Stream 1-to-M_COUNT demultiplexer that routes whole packets by tdest.
// The destination is taken from the first beat of each packet and held until
// tlast; tdest on later beats is ignored. Outputs come from a registered
// output stage backed by a skid (temp) register, so s_axis_tready is a
// register and there is no combinational ready path from the outputs.
//
// Optional feature (compile-time macro AXIS_DEMUX_DROP_EN):
//   defined   : packets whose first-beat tdest >= M_COUNT are consumed and
//               discarded; stat_drop pulses for one cycle after the dropped
//               packet's tlast beat is accepted.
//   undefined : out-of-range packets are sent to port M_COUNT-1 and
//               stat_drop is tied low.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   s_axis_*          shared input stream (tdata/tkeep/tvalid/tready/tlast/
//                     tid/tdest/tuser)
//   m_axis_*          M_COUNT output streams, flattened into vectors; all
//                     ports carry the same payload, tvalid is one-hot-or-zero
//   stat_drop         dropped-packet pulse
// ---------------------------------------------------------------------------
module axis_dest_demux #(
   parameter int M_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter int ID_ENABLE   = 0,
   parameter int ID_WIDTH    = 8,
   parameter int DEST_WIDTH  = 8,
   parameter int USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1
) (
   input  logic                           clk,
   input  logic                           rst,

   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   input  logic [ID_WIDTH-1:0]            s_axis_tid,
   input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
   input  logic [USER_WIDTH-1:0]          s_axis_tuser,

   output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
   output logic [M_COUNT-1:0]             m_axis_tvalid,
   input  logic [M_COUNT-1:0]             m_axis_tready,
   output logic [M_COUNT-1:0]             m_axis_tlast,
   output logic [M_COUNT*ID_WIDTH-1:0]    m_axis_tid,
   output logic [M_COUNT*DEST_WIDTH-1:0]  m_axis_tdest,
   output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser,

   output logic                           stat_drop
);

   localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
   localparam logic [SEL_W-1:0]      LAST_PORT  = SEL_W'(M_COUNT - 1);
   // One extra bit so that M_COUNT == 2**DEST_WIDTH is representable.
   localparam logic [DEST_WIDTH:0]   DEST_LIMIT = (DEST_WIDTH + 1)'(M_COUNT);
   localparam int BEAT_W = SEL_W + DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH
                         + DEST_WIDTH + USER_WIDTH;

   // ------------------------------------------------------------------
   // Route FSM
   // ------------------------------------------------------------------
`ifdef AXIS_DEMUX_DROP_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1
   } state_t;
`endif

   state_t                r_state;
   state_t                w_state_next;
   logic [SEL_W-1:0]      r_select;
   logic [DEST_WIDTH-1:0] r_dest;
   logic                  r_s_ready;

   logic                  w_accept;
   logic                  w_first;
   logic                  w_in_range;
   logic [SEL_W-1:0]      w_first_sel;
   logic [SEL_W-1:0]      w_beat_sel;
   logic [DEST_WIDTH-1:0] w_beat_dest;
   logic                  w_drop_beat;
   logic                  w_int_valid;

   assign w_accept    = s_axis_tvalid && r_s_ready;
   assign w_first     = (r_state == ST_IDLE);
   assign w_in_range  = ({1'b0, s_axis_tdest} < DEST_LIMIT);
   assign w_first_sel = w_in_range ? SEL_W'(s_axis_tdest) : LAST_PORT;

   // The first beat routes straight from tdest; later beats use the latch.
   assign w_beat_sel  = w_first ? w_first_sel  : r_select;
   assign w_beat_dest = w_first ? s_axis_tdest : r_dest;

`ifdef AXIS_DEMUX_DROP_EN
   assign w_drop_beat = w_first ? !w_in_range : (r_state == ST_DROP);
`else
   assign w_drop_beat = 1'b0;
`endif

   // Beat presented to the output stage this cycle.
   assign w_int_valid = w_accept && !w_drop_beat;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            // A single-beat packet never leaves IDLE.
            if (w_accept && !s_axis_tlast) begin
`ifdef AXIS_DEMUX_DROP_EN
               w_state_next = w_in_range ? ST_PASS : ST_DROP;
`else
               w_state_next = ST_PASS;
`endif
            end
         end
         ST_PASS: begin
            if (w_accept && s_axis_tlast) begin
               w_state_next = ST_IDLE;
            end
         end
`ifdef AXIS_DEMUX_DROP_EN
         ST_DROP: begin
            if (w_accept && s_axis_tlast) begin
               w_state_next = ST_IDLE;
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_select <= '0;
         r_dest   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept && w_first) begin
            r_select <= w_first_sel;
            r_dest   <= s_axis_tdest;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register + skid register
   // ------------------------------------------------------------------
   logic [BEAT_W-1:0]     w_int_beat;
   logic [BEAT_W-1:0]     r_out_beat;
   logic [BEAT_W-1:0]     r_temp_beat;
   logic                  r_out_valid;
   logic                  r_temp_valid;

   logic                  w_out_valid_next;
   logic                  w_temp_valid_next;
   logic                  w_store_int_to_out;
   logic                  w_store_int_to_temp;
   logic                  w_store_temp_to_out;
   logic                  w_sel_ready;
   logic                  w_s_ready_next;

   logic [SEL_W-1:0]      w_out_sel;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic [KEEP_WIDTH-1:0] w_out_keep;
   logic                  w_out_last;
   logic [ID_WIDTH-1:0]   w_out_id;
   logic [DEST_WIDTH-1:0] w_out_dest;
   logic [USER_WIDTH-1:0] w_out_user;

   assign w_int_beat = {w_beat_sel, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                        s_axis_tid, w_beat_dest, s_axis_tuser};

   assign {w_out_sel, w_out_data, w_out_keep, w_out_last,
           w_out_id, w_out_dest, w_out_user} = r_out_beat;

   // Only the port currently holding the output register can drain it.
   assign w_sel_ready = m_axis_tready[w_out_sel];

   // Ready for next cycle: either the output is draining now, or the skid
   // register is free and the output will not fill from this cycle's beat.
   assign w_s_ready_next = w_sel_ready ||
                           (!r_temp_valid && (!r_out_valid || !w_int_valid));

   always_comb begin
      w_out_valid_next    = r_out_valid;
      w_temp_valid_next   = r_temp_valid;
      w_store_int_to_out  = 1'b0;
      w_store_int_to_temp = 1'b0;
      w_store_temp_to_out = 1'b0;
      if (r_s_ready) begin
         // The skid register is always empty while ready is high.
         if (w_sel_ready || !r_out_valid) begin
            w_out_valid_next   = w_int_valid;
            w_store_int_to_out = 1'b1;
         end else begin
            w_temp_valid_next   = w_int_valid;
            w_store_int_to_temp = 1'b1;
         end
      end else if (w_sel_ready) begin
         w_out_valid_next    = r_temp_valid;
         w_temp_valid_next   = 1'b0;
         w_store_temp_to_out = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_temp_valid <= 1'b0;
         r_s_ready    <= 1'b0;
      end else begin
         r_out_valid  <= w_out_valid_next;
         r_temp_valid <= w_temp_valid_next;
         r_s_ready    <= w_s_ready_next;
      end
   end

   // Payload registers carry no reset; their valid flags qualify them.
   always_ff @(posedge clk) begin
      if (w_store_int_to_out) begin
         r_out_beat <= w_int_beat;
      end else if (w_store_temp_to_out) begin
         r_out_beat <= r_temp_beat;
      end
      if (w_store_int_to_temp) begin
         r_temp_beat <= w_int_beat;
      end
   end

   assign s_axis_tready = r_s_ready;

   // ------------------------------------------------------------------
   // Drop statistics
   // ------------------------------------------------------------------
`ifdef AXIS_DEMUX_DROP_EN
   logic r_stat_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_drop <= 1'b0;
      end else begin
         r_stat_drop <= w_accept && s_axis_tlast && w_drop_beat;
      end
   end

   assign stat_drop = r_stat_drop;
`else
   assign stat_drop = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Per-port fan-out
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < M_COUNT; gi++) begin : g_port
         assign m_axis_tvalid[gi] = r_out_valid && (w_out_sel == SEL_W'(gi));
         assign m_axis_tlast[gi]  = w_out_last;
         assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_out_data;
         assign m_axis_tdest[gi*DEST_WIDTH +: DEST_WIDTH] = w_out_dest;
         assign m_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH] =
            (KEEP_ENABLE != 0) ? w_out_keep : {KEEP_WIDTH{1'b1}};
         assign m_axis_tid[gi*ID_WIDTH +: ID_WIDTH] =
            (ID_ENABLE != 0) ? w_out_id : {ID_WIDTH{1'b0}};
         assign m_axis_tuser[gi*USER_WIDTH +: USER_WIDTH] =
            (USER_ENABLE != 0) ? w_out_user : {USER_WIDTH{1'b0}};
      end
   endgenerate

endmodule
